subleq_sequencer: RTL and testbench

Control FSM that sequences the single-instruction (SUBLEQ) datapath: fetches the three operand addresses, reads both operands, writes the difference back and selects the next PC. Sits between the core's shared single-port memory (req/ack handshake, variable wait states) and the PC/status visible to the rest of the design. All state advances on the rising edge of the core clock.

---
 rtl/subleq_sequencer.sv | 156 +++++++++++++++
 tb/tb_subleq_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_sequencer.sv
// subleq_sequencer: control FSM for a SUBLEQ core on a shared single-port
// memory. Each instruction is three operand-address fetches, two operand
// reads and one write-back. The core then takes the branch or steps the PC.
// All memory-side outputs are registers. They only change on an accepted
// ack, so they stay stable while the memory inserts wait states.

module subleq_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] START_PC = {ADDR_W{1'b0}}
) (
    input  logic              clkIn,
    input  logic              reset,
    input  logic              start,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [15:0]       instr_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH_A = 3'd1,
        ST_FETCH_B = 3'd2,
        ST_FETCH_C = 3'd3,
        ST_READ_A  = 3'd4,
        ST_READ_B  = 3'd5,
        ST_WRITE_B = 3'd6,
        ST_HALT    = 3'd7
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] a_r;
    logic [ADDR_W-1:0] b_r;
    logic [ADDR_W-1:0] c_r;
    logic [DATA_W-1:0] opa_r;
    logic [DATA_W-1:0] diff_r;

    logic              leq_s;
    logic              halt_s;
    logic [ADDR_W-1:0] seq_pc_s;
    logic [ADDR_W-1:0] next_pc_s;

    // The write data is the difference register itself. It is held from READ_B until the write is acked.
    assign mem_wdata = diff_r;

    // Branch decision and next-PC selection, taken from the stored difference and operand addresses.
    always_comb begin
        leq_s     = diff_r[DATA_W-1] | (diff_r == {DATA_W{1'b0}});
        seq_pc_s  = pc + ADDR_W'(2'd3);
        next_pc_s = leq_s ? c_r : seq_pc_s;
        halt_s    = leq_s & (c_r == pc);
    end

    // Sequencer: advance on ack, latch operands, and update the PC, count and status.
    always_ff @(posedge clkIn) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            a_r         <= {ADDR_W{1'b0}};
            b_r         <= {ADDR_W{1'b0}};
            c_r         <= {ADDR_W{1'b0}};
            opa_r       <= {DATA_W{1'b0}};
            diff_r      <= {DATA_W{1'b0}};
            pc          <= START_PC;
            busy        <= 1'b0;
            halted      <= 1'b0;
            instr_count <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_r     <= ST_FETCH_A;
                        pc          <= START_PC;
                        instr_count <= 16'd0;
                        mem_req     <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_addr    <= START_PC;
                        busy        <= 1'b1;
                        halted      <= 1'b0;
                    end
                end
                ST_FETCH_A: begin
                    if (mem_ack) begin
                        a_r      <= mem_rdata[ADDR_W-1:0];
                        mem_addr <= pc + ADDR_W'(2'd1);
                        state_r  <= ST_FETCH_B;
                    end
                end
                ST_FETCH_B: begin
                    if (mem_ack) begin
                        b_r      <= mem_rdata[ADDR_W-1:0];
                        mem_addr <= pc + ADDR_W'(2'd2);
                        state_r  <= ST_FETCH_C;
                    end
                end
                ST_FETCH_C: begin
                    if (mem_ack) begin
                        c_r      <= mem_rdata[ADDR_W-1:0];
                        mem_addr <= a_r;
                        state_r  <= ST_READ_A;
                    end
                end
                ST_READ_A: begin
                    if (mem_ack) begin
                        opa_r    <= mem_rdata;
                        mem_addr <= b_r;
                        state_r  <= ST_READ_B;
                    end
                end
                ST_READ_B: begin
                    // The operand B word goes straight into the difference; it is not needed afterwards.
                    if (mem_ack) begin
                        diff_r  <= mem_rdata - opa_r;
                        mem_we  <= 1'b1;
                        state_r <= ST_WRITE_B;
                    end
                end
                ST_WRITE_B: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        if (instr_count != 16'hFFFF) begin
                            instr_count <= instr_count + 16'd1;
                        end
                        if (halt_s) begin
                            state_r <= ST_HALT;
                            mem_req <= 1'b0;
                            busy    <= 1'b0;
                            halted  <= 1'b1;
                        end else begin
                            pc       <= next_pc_s;
                            mem_addr <= next_pc_s;
                            state_r  <= ST_FETCH_A;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subleq_sequencer.sv
// Testbench for subleq_sequencer. It provides a behavioural memory with
// programmable wait states. Its reference model is an instruction-level
// SUBLEQ interpreter working on its own copy of memory.

module tb_subleq_sequencer;

    logic        clkIn = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mem_req, mem_we, mem_ack, busy, halted;
    logic [7:0]  mem_addr, pc;
    logic [15:0] mem_wdata, mem_rdata, instr_count;

    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    logic [7:0]  ref_pc;
    logic [15:0] ref_cnt;
    logic        ref_halt;

    int checks = 0;
    int errors = 0;

    logic       ack_en     = 1'b1;
    logic       rand_waits = 1'b0;
    logic       slow_en    = 1'b0;
    logic [7:0] slow_addr  = 8'd0;
    int         wcnt       = 0;
    int         wait_n     = 0;
    int         eff_wait;
    int         glitch_cyc = 0;
    int         slow_cycles;

    always #5 clkIn = ~clkIn;

    subleq_sequencer dut (
        .clkIn       (clkIn),
        .reset       (reset),
        .start       (start),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    assign mem_rdata = mem[mem_addr];
    always_comb eff_wait = (slow_en && !mem_we && mem_addr == slow_addr) ? 3 : wait_n;
    assign mem_ack = ack_en && mem_req && (wcnt >= eff_wait);

    // Wait-state counter: counts cycles of an outstanding request and picks the next delay on each ack.
    always @(posedge clkIn) begin
        if (mem_req && !mem_ack) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
            if (mem_req) wait_n <= rand_waits ? int'($urandom_range(0, 2)) : 0;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'd0;
            ref_mem[i] = 16'd0;
        end
    endtask

    task automatic load(input int addr, input logic [15:0] val);
        mem[addr] = val;
        ref_mem[addr] = val;
    endtask

    task automatic do_reset();
        @(negedge clkIn);
        reset = 1'b1;
        @(posedge clkIn);
        @(negedge clkIn);
        reset  = 1'b0;
        ack_en = 1'b1;
    endtask

    task automatic do_start();
        @(negedge clkIn);
        start = 1'b1;
        @(posedge clkIn);
        #1;
        start    = 1'b0;
        ref_pc   = 8'd0;
        ref_cnt  = 16'd0;
        ref_halt = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'd0 || busy !== 1'b1 || halted !== 1'b0 || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL start_state got req=%b addr=%0d busy=%b halted=%b cnt=%0d exp 1 0 1 0 0",
                     mem_req, mem_addr, busy, halted, instr_count);
        end
    endtask

    // Executes one instruction on the DUT and on the reference interpreter, then compares them.
    task automatic run_instr(output int cyc);
        logic [7:0]  p1, p2, ea, eb, ec;
        logic [7:0]  exp_addr [6];
        logic [7:0]  got_addr [6];
        logic [15:0] ediff, got_wdata;
        logic        leq, done;
        int          n;
        p1 = ref_pc + 8'd1;
        p2 = ref_pc + 8'd2;
        ea = ref_mem[ref_pc][7:0];
        eb = ref_mem[p1][7:0];
        ec = ref_mem[p2][7:0];
        ediff = ref_mem[eb] - ref_mem[ea];
        leq = ($signed(ediff) <= 0);
        exp_addr[0] = ref_pc; exp_addr[1] = p1; exp_addr[2] = p2;
        exp_addr[3] = ea;     exp_addr[4] = eb; exp_addr[5] = eb;
        for (int i = 0; i < 6; i++) got_addr[i] = 8'hxx;
        got_wdata = 16'hxxxx;
        n = 0; cyc = 0; done = 1'b0; slow_cycles = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clkIn);
            cyc++;
            start = (cyc == glitch_cyc);
            if (mem_req && !mem_we && slow_en && mem_addr == slow_addr) slow_cycles++;
            if (mem_req && mem_ack) begin
                if (n < 6) got_addr[n] = mem_addr;
                if (mem_we) begin
                    got_wdata = mem_wdata;
                    mem[mem_addr] = mem_wdata;
                    done = 1'b1;
                end
                n++;
            end
        end
        start = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL write_timeout got no write exp write to %0d", eb); end
        checks++;
        if (n !== 6) begin errors++; $display("FAIL access_count got %0d exp 6", n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i]) begin
                errors++;
                $display("FAIL access_addr[%0d] got %0d exp %0d", i, got_addr[i], exp_addr[i]);
            end
        end
        checks++;
        if (got_wdata !== ediff) begin errors++; $display("FAIL write_data got %0h exp %0h", got_wdata, ediff); end
        ref_mem[eb] = ediff;
        if (ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
        if (leq && ec == ref_pc) ref_halt = 1'b1;
        else ref_pc = leq ? ec : ref_pc + 8'd3;
        @(posedge clkIn);
        #1;
        checks++;
        if (pc !== ref_pc) begin errors++; $display("FAIL pc got %0d exp %0d", pc, ref_pc); end
        checks++;
        if (instr_count !== ref_cnt) begin errors++; $display("FAIL instr_count got %0d exp %0d", instr_count, ref_cnt); end
        checks++;
        if (halted !== ref_halt || busy !== !ref_halt) begin
            errors++;
            $display("FAIL status got halted=%b busy=%b exp halted=%b busy=%b", halted, busy, ref_halt, !ref_halt);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'd0 || mem_wdata !== 16'd0 || pc !== 8'd0 ||
            busy !== 1'b0 || halted !== 1'b0 || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL %s got req=%b we=%b addr=%0d wdata=%0h pc=%0d busy=%b halted=%b cnt=%0d exp all zero",
                     tag, mem_req, mem_we, mem_addr, mem_wdata, pc, busy, halted, instr_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        @(posedge clkIn);
        @(posedge clkIn);
        #1;
        check_reset_outputs("reset_with_start");
        @(negedge clkIn);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clkIn);
        #1;
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_no_branch();
        int cyc;
        clear_mem();
        load(0, 16'd10); load(1, 16'd11); load(2, 16'd20);
        load(10, 16'd3); load(11, 16'd5);
        do_start();
        glitch_cyc = 3;
        run_instr(cyc);
        glitch_cyc = 0;
        checks++;
        if (cyc !== 6) begin errors++; $display("FAIL no_branch_cycles got %0d exp 6", cyc); end
        checks++;
        if (mem[11] !== 16'd2 || pc !== 8'd3) begin
            errors++;
            $display("FAIL no_branch_result got mem11=%0d pc=%0d exp 2 3", mem[11], pc);
        end
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clkIn);
            if (mem_req && mem_addr == 8'd4) found = 1'b1;
        end
        ack_en = 1'b0;
        @(negedge clkIn);
        checks++;
        if (!found || mem_req !== 1'b1 || mem_addr !== 8'd4) begin
            errors++;
            $display("FAIL hold_fetch_b got req=%b addr=%0d exp 1 4", mem_req, mem_addr);
        end
        reset = 1'b1;
        @(posedge clkIn);
        #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL req_after_reset got %b exp 0", mem_req); end
        ack_en = 1'b1;
        @(posedge clkIn);
        @(negedge clkIn);
        reset = 1'b0;
        check_reset_outputs("reset_mid_fetch_b");
        for (int k = 0; k < 4; k++) begin
            @(negedge clkIn);
            checks++;
            if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL stay_idle got req=%b we=%b exp 0 0", mem_req, mem_we);
            end
        end
    endtask

    task automatic test_branch();
        int cyc;
        do_reset();
        clear_mem();
        load(0, 16'd10); load(1, 16'd11); load(2, 16'd20);
        load(10, 16'd5); load(11, 16'd5);
        do_start();
        run_instr(cyc);
        checks++;
        if (mem[11] !== 16'd0 || pc !== 8'd20) begin
            errors++;
            $display("FAIL branch_zero got mem11=%0h pc=%0d exp 0 20", mem[11], pc);
        end
        do_reset();
        load(11, 16'd4);
        do_start();
        run_instr(cyc);
        checks++;
        if (mem[11] !== 16'hFFFF || pc !== 8'd20) begin
            errors++;
            $display("FAIL branch_neg got mem11=%0h pc=%0d exp ffff 20", mem[11], pc);
        end
    endtask

    task automatic test_halt();
        int cyc;
        do_reset();
        clear_mem();
        load(0, 16'd10); load(1, 16'd10); load(2, 16'd0);
        load(10, 16'd7);
        do_start();
        run_instr(cyc);
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'd0 || instr_count !== 16'd1 || mem[10] !== 16'd0) begin
            errors++;
            $display("FAIL halt got halted=%b busy=%b pc=%0d cnt=%0d mem10=%0h exp 1 0 0 1 0",
                     halted, busy, pc, instr_count, mem[10]);
        end
        @(negedge clkIn);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL halt_no_req got %b exp 0", mem_req); end
        do_start();
        run_instr(cyc);
    endtask

    task automatic test_wait_states();
        int cyc;
        do_reset();
        clear_mem();
        load(0, 16'd10); load(1, 16'd11); load(2, 16'd20);
        load(10, 16'd3); load(11, 16'd5);
        slow_en = 1'b1;
        slow_addr = 8'd10;
        do_start();
        run_instr(cyc);
        slow_en = 1'b0;
        checks++;
        if (cyc !== 9 || slow_cycles !== 4) begin
            errors++;
            $display("FAIL wait_states got cycles=%0d held=%0d exp 9 4", cyc, slow_cycles);
        end
        checks++;
        if (mem[11] !== 16'd2 || pc !== 8'd3) begin
            errors++;
            $display("FAIL wait_result got mem11=%0d pc=%0d exp 2 3", mem[11], pc);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        do_reset();
        clear_mem();
        load(0, 16'd30); load(1, 16'd30); load(2, 16'd254);
        load(254, 16'd10); load(255, 16'd11);
        load(10, 16'd3); load(11, 16'd5);
        do_start();
        run_instr(cyc);
        run_instr(cyc);
        checks++;
        if (pc !== 8'd1 || mem[11] !== 16'd2) begin
            errors++;
            $display("FAIL wrap got pc=%0d mem11=%0d exp 1 2", pc, mem[11]);
        end
    endtask

    task automatic test_random();
        int cyc, bad;
        do_reset();
        for (int i = 0; i < 256; i++) load(i, 16'($urandom));
        rand_waits = 1'b1;
        do_start();
        for (int n = 0; n < 40 && !ref_halt; n++) run_instr(cyc);
        rand_waits = 1'b0;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL random_mem got %0d differing words exp 0", bad); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_no_branch();
        test_reset_mid();
        test_branch();
        test_halt();
        test_wait_states();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
